// File: rtl/encoder_emu.sv
// ============================================================================
// Module   : encoder_emu
// Brief    : Quadrature encoder emulator; deg/s rate + direction -> A/B phases.
// Revision : 1.0
// ============================================================================
`default_nettype none

module encoder_emu #(
   parameter int CLK_HZ    = 16000000,
   parameter int MAX_DEG_S = 1440,
   parameter int ACC_W     = 32
) (
   input  logic        clk,
   input  logic        enable,
   input  logic [15:0] deg_s,
   input  logic        dir,
   output logic        enc_a,
   output logic        enc_b,
   output logic        step,
   output logic [15:0] edge_count
);

   localparam logic [ACC_W-1:0] c_clk_hz    = ACC_W'(CLK_HZ);
   localparam logic [15:0]      c_max_deg_s = 16'(MAX_DEG_S);

   // Encoding equals the {A,B} level pair, so the state register drives the pins.
   typedef enum logic [1:0] {
      QS_00 = 2'b00,
      QS_10 = 2'b10,
      QS_11 = 2'b11,
      QS_01 = 2'b01
   } quad_t;

   logic [ACC_W-1:0] acc_q, acc_d;
   quad_t            quad_q, quad_d;
   logic             step_q, step_d;
   logic [15:0]      edge_count_q, edge_count_d;

   logic [15:0]      w_rate;
   logic [ACC_W-1:0] w_inc;
   logic [ACC_W-1:0] w_sum;
   logic             w_wrap;

   always_comb begin
      w_rate       = (deg_s > c_max_deg_s) ? c_max_deg_s : deg_s;
      w_inc        = {{(ACC_W-18){1'b0}}, w_rate, 2'b00};
      w_sum        = acc_q + w_inc;
      w_wrap       = (w_sum >= c_clk_hz);
      acc_d        = w_wrap ? (w_sum - c_clk_hz) : w_sum;
      step_d       = w_wrap;
      quad_d       = quad_q;
      edge_count_d = edge_count_q;

      if (w_wrap) begin
         case (quad_q)
            QS_00:   quad_d = dir ? QS_01 : QS_10;
            QS_10:   quad_d = dir ? QS_00 : QS_11;
            QS_11:   quad_d = dir ? QS_10 : QS_01;
            QS_01:   quad_d = dir ? QS_11 : QS_00;
            default: quad_d = QS_00;
         endcase
      end

      // Count only the A 0->1 transition, regardless of direction.
      if (!quad_q[1] && quad_d[1]) begin
         edge_count_d = edge_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge enable) begin
      if (!enable) begin
         acc_q        <= '0;
         quad_q       <= QS_00;
         step_q       <= 1'b0;
         edge_count_q <= 16'd0;
      end else begin
         acc_q        <= acc_d;
         quad_q       <= quad_d;
         step_q       <= step_d;
         edge_count_q <= edge_count_d;
      end
   end

   assign enc_a      = quad_q[1];
   assign enc_b      = quad_q[0];
   assign step       = step_q;
   assign edge_count = edge_count_q;

endmodule

`default_nettype wire

// File: doc/encoder_emu.md
Name: encoder_emu

Overview:
- Quadrature encoder emulator: the signal source for the motor speed controller's encoder input.
- Converts a commanded rotation rate (degrees per second) plus direction into A/B quadrature waveforms.
- Produces one rising edge of enc_a per degree, so a speed controller counting enc_a rising edges sees exactly deg_s edges per second.
- Used in closed-loop simulation benches and as a bench-top stand-in for a real motor.

Parameters:
- CLK_HZ, 16000000, clock frequency in Hz; also the phase-accumulator wrap threshold.
- MAX_DEG_S, 1440, saturation limit applied to deg_s.
- ACC_W, 32, phase-accumulator width; must hold CLK_HZ + 4*MAX_DEG_S.

Ports:
- clk  in  1  system clock (16 MHz nominal).
- enable  in  1  asynchronous, active-low reset; low clears all state immediately.
- deg_s  in  16  commanded rate, unsigned deg/s; sampled every cycle.
- dir  in  1  0 = forward, 1 = reverse; sampled every cycle.
- enc_a  out  1  quadrature channel A, registered.
- enc_b  out  1  quadrature channel B, registered.
- step  out  1  one-cycle strobe, high in the cycle after each quadrature state change.
- edge_count  out  16  count of enc_a rising edges since reset; wraps.

Behaviour:
- Reset (enable low, asynchronous):
  - acc=0, quadrature state {A,B}=00.
  - enc_a=0, enc_b=0, step=0, edge_count=0.
  - Outputs hold these values while enable is low. Normal operation starts on the first clk edge after enable rises.
- Rate clamp (combinational): rate = min(deg_s, MAX_DEG_S). Increment inc = rate<<2, giving four quadrature steps per degree.
- Each clk edge: sum = acc + inc.
  - If sum >= CLK_HZ: acc <= sum - CLK_HZ and advance the quadrature state by one step.
  - Otherwise: acc <= sum and the state holds.
- At most one step per clock. This is guaranteed because 4*MAX_DEG_S < CLK_HZ.
- Quadrature sequence ({A,B}):
  - Forward: 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse: the exact inverse sequence.
  - Only one of A/B changes per step; no glitches.
- Latency:
  - enc_a/enc_b change on the same edge where the threshold is crossed (registered state drives outputs directly).
  - step is high for exactly the following cycle.
- edge_count increments on the edge where enc_a goes 0->1, in either direction. It wraps 65535 -> 0.
- deg_s = 0: acc holds, no steps, outputs frozen at their current levels. Resuming continues from the frozen phase.
- deg_s > MAX_DEG_S: behaves identically to deg_s = MAX_DEG_S.
- dir change mid-rotation:
  - The next step moves in the new direction from the current state, with no skipped state.
  - The accumulator is not cleared, so the rate is continuous.
- Rate change mid-period: the new inc applies from the next cycle; the accumulator phase is preserved, with no reset of the period.
- enable low mid-rotation: immediate return to the reset values. The phase is lost.
- Long-run accuracy: over N*CLK_HZ cycles at constant rate, step count = 4*rate*N exactly, with no drift.

Test Plan:
- CLK_HZ=16000, deg_s=1000, dir=0, after reset → first step on the 4th clk edge, then a step every 4 cycles. enc_a period is 16 cycles. After 16000 cycles, edge_count=1000 and the A/B sequence is 00,10,11,01.
- CLK_HZ=16000, deg_s=0 for 500 cycles, then 250 → no output changes for 500 cycles. Then a step every 16 cycles: acc+=1000, wrap at 16000.
- deg_s=5000 with MAX_DEG_S=1440 → step timing identical to a deg_s=1440 run. Over 16000 cycles, edge_count=1440.
- Forward at deg_s=1000; flip dir=1 while state is 11 → next state is 10, then 00, 01, 11. A and B never change in the same cycle. edge_count increments only on enc_a 0->1.
- Running at deg_s=1000; assert enable low asynchronously mid-cycle → enc_a=enc_b=step=0 and edge_count=0 before the next clk edge. After release, behaviour matches the first scenario.
- Preload a run long enough to reach edge_count=65535 → the next enc_a rising edge gives edge_count=0.
